ex_alu_branch_unit: RTL and testbench

- Execute-stage arithmetic and next-PC helper for the 5-stage RV32 pipeline.
- Contains three functions:
  - Combinational ALU producing a result plus zero/neg flags.
  - Registered PC+4 incrementer for the fetch stage.
  - Combinational branch-decision logic producing pcsrc for the PC mux.
- Sits between the ID/EX register (ALU operands) and the EX/MEM register (flags, branch code).

---
 rtl/ex_alu_branch_unit_pkg.sv | 27 ++
 rtl/ex_alu_branch_unit_alu.sv | 58 +++++
 rtl/ex_alu_branch_unit.sv | 62 ++++++
 tb/tb_ex_alu_branch_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ex_alu_branch_unit_pkg.sv
// ex_pkg: shared constants for the execute-stage ALU / branch unit.
//   - aluop codes (5-bit), branch codes (3-bit), default widths.
//   - Optional feature macro: ALU_MUL_EN (claims aluop 11 MUL / 12 MULH).
package ex_pkg;
    localparam int XLEN_DEF = 32;
    localparam int PC_W_DEF = 12;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_SRL   = 5'd5;
    localparam logic [4:0] ALU_SRA   = 5'd6;
    localparam logic [4:0] ALU_OR    = 5'd7;
    localparam logic [4:0] ALU_AND   = 5'd8;
    localparam logic [4:0] ALU_PASSB = 5'd9;
    localparam logic [4:0] ALU_MUL   = 5'd11;
    localparam logic [4:0] ALU_MULH  = 5'd12;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_EQ   = 3'd1;
    localparam logic [2:0] BR_NE   = 3'd2;
    localparam logic [2:0] BR_LT   = 3'd3;
    localparam logic [2:0] BR_GE   = 3'd4;
    localparam logic [2:0] BR_JUMP = 3'd5;
endpackage

// File: rtl/ex_alu_branch_unit_alu.sv
// ex_alu: combinational RV32 ALU with zero/neg flags.
//   aluop  - operation code (ex_pkg ALU_*); unassigned codes give result 0
//   sign   - 1 = signed compare / signed MULH operands, 0 = unsigned
//   op1,op2- operands; shifts only look at op2[4:0]
//   result - ALU result; zero = (result == 0); neg = op1 < op2 (any aluop)
//   Optional: `define ALU_MUL_EN adds MUL (11) and MULH (12).
module ex_alu
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [4:0]      aluop,
    input  logic            sign,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            neg
);
    logic [4:0] shamt;
    logic       lt;

    assign shamt = op2[4:0];
    assign lt    = sign ? ($signed(op1) < $signed(op2)) : (op1 < op2);

`ifdef ALU_MUL_EN
    // Extend both operands to 2*XLEN (sign- or zero-extended) so a single
    // unsigned multiply yields the correct two's-complement full product.
    logic [2*XLEN-1:0] ext1, ext2, prod;
    assign ext1 = {{XLEN{sign & op1[XLEN-1]}}, op1};
    assign ext2 = {{XLEN{sign & op2[XLEN-1]}}, op2};
    assign prod = ext1 * ext2;
`endif

    always_comb begin
        result = '0;
        case (aluop)
            ALU_ADD:   result = op1 + op2;
            ALU_SUB:   result = op1 - op2;
            ALU_SLL:   result = op1 << shamt;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, lt};
            ALU_XOR:   result = op1 ^ op2;
            ALU_SRL:   result = op1 >> shamt;
            ALU_SRA:   result = $unsigned($signed(op1) >>> shamt);
            ALU_OR:    result = op1 | op2;
            ALU_AND:   result = op1 & op2;
            ALU_PASSB: result = op2;
`ifdef ALU_MUL_EN
            ALU_MUL:   result = prod[XLEN-1:0];
            ALU_MULH:  result = prod[2*XLEN-1:XLEN];
`endif
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);
    assign neg  = lt;
endmodule

// File: rtl/ex_alu_branch_unit.sv
// ex_alu_branch_unit: execute-stage ALU, registered PC+4, branch decision.
//   clk, rst_n         - clock (rising), async active-low reset (pc4 only)
//   aluop, sign, op1, op2 -> result, zero, neg   (combinational, ex_alu)
//   pc_in -> pc4       - pc4 <= pc_in + 4 (mod 2^PC_W), cleared by reset
//   branch, br_zero, br_neg -> pcsrc   (combinational)
//   Optional: `define ALU_MUL_EN enables MUL/MULH in the ALU.
module ex_alu_branch_unit
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      aluop,
    input  logic            sign,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            neg,
    input  logic [PC_W-1:0] pc_in,
    output logic [PC_W-1:0] pc4,
    input  logic [2:0]      branch,
    input  logic            br_zero,
    input  logic            br_neg,
    output logic            pcsrc
);
    logic [PC_W-1:0] pc4_d, pc4_q;

    ex_alu #(.XLEN(XLEN)) u_alu (
        .aluop  (aluop),
        .sign   (sign),
        .op1    (op1),
        .op2    (op2),
        .result (result),
        .zero   (zero),
        .neg    (neg)
    );

    // Wraps modulo 2^PC_W by truncation.
    always_comb pc4_d = pc_in + PC_W'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc4_q <= '0;
        else        pc4_q <= pc4_d;
    end

    assign pc4 = pc4_q;

    always_comb begin
        pcsrc = 1'b0;
        case (branch)
            BR_EQ:   pcsrc = br_zero;
            BR_NE:   pcsrc = ~br_zero;
            BR_LT:   pcsrc = br_neg;
            BR_GE:   pcsrc = ~br_neg;
            BR_JUMP: pcsrc = 1'b1;
            default: pcsrc = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_ex_alu_branch_unit.sv
module tb_ex_alu_branch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  aluop;
    logic        sign;
    logic [31:0] op1, op2, result;
    logic        zero, neg;
    logic [11:0] pc_in, pc4;
    logic [2:0]  branch;
    logic        br_zero, br_neg, pcsrc;

    int passed = 0;
    int total  = 0;

    ex_alu_branch_unit #(.XLEN(32), .PC_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .aluop(aluop), .sign(sign), .op1(op1), .op2(op2),
        .result(result), .zero(zero), .neg(neg), .pc_in(pc_in), .pc4(pc4),
        .branch(branch), .br_zero(br_zero), .br_neg(br_neg), .pcsrc(pcsrc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference model: plain 64-bit arithmetic on the documented rules.
    function automatic logic ref_lt(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        return sa < sb;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic s,
                                            input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub, pw;
        longint sa;
        int sh;
        logic [63:0] full;
        sh = int'(b % 32);
        pw = 64'd1 << sh;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        full = 64'd0;
        case (op)
            5'd0: full = ua + ub;
            5'd1: full = ua - ub;
            5'd2: full = ua * pw;
            5'd3: full = {63'd0, ref_lt(s, a, b)};
            5'd4: full = ua ^ ub;
            5'd5: full = ua / pw;
            5'd6: full = sa >>> sh;
            5'd7: full = ua | ub;
            5'd8: full = ua & ub;
            5'd9: full = ub;
`ifdef ALU_MUL_EN
            5'd11: full = s ? longint'($signed(a)) * longint'($signed(b)) : ua * ub;
            5'd12: begin
                full = s ? longint'($signed(a)) * longint'($signed(b)) : ua * ub;
                full = full >> 32;
            end
`endif
            default: full = 64'd0;
        endcase
        return full[31:0];
    endfunction

    function automatic logic ref_pcsrc(input int b, input logic z, input logic n);
        case (b)
            1: return z;
            2: return !z;
            3: return n;
            4: return !n;
            5: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic alu(input string tag, input int op, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_neg);
        aluop = 5'(op); sign = s; op1 = a; op2 = b;
        #1;
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
        chk({tag, "_neg"}, {31'd0, neg}, {31'd0, exp_neg});
    endtask

    initial begin
        logic [31:0] a, b, e;
        logic [11:0] p;
        logic s;
        int op;
        rst_n = 1'b0; pc_in = 12'h010; aluop = 5'd0; sign = 1'b0;
        op1 = 32'd0; op2 = 32'd0; branch = 3'd0; br_zero = 1'b0; br_neg = 1'b0;

        // Reset and pc4
        #1 chk("pc4_reset", 32'(pc4), 32'h0);
        @(posedge clk); #1 chk("pc4_held_in_reset", 32'(pc4), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 chk("pc4_first", 32'(pc4), 32'h014);
        @(negedge clk) pc_in = 12'hFFC;
        @(posedge clk); #1 chk("pc4_wrap", 32'(pc4), 32'h000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) p = 12'($urandom); pc_in = p;
            @(posedge clk); #1 chk("pc4_rand", 32'(pc4), 32'((p + 12'd4) & 12'hFFF));
        end
        @(negedge clk) rst_n = 1'b0;
        #1 chk("pc4_async_clear", 32'(pc4), 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Directed ALU cases
        alu("add_ovf",  0, 1'b1, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0);
        alu("sub_zero", 1, 1'b0, 32'd5, 32'd5, 32'h0, 1'b0);
        alu("sub_wrap", 1, 1'b0, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b1);
        alu("sll_mask", 2, 1'b0, 32'd1, 32'h21, 32'd2, 1'b1);
        alu("sll_zero", 2, 1'b0, 32'h1234, 32'h40, 32'h1234, 1'b0);
        alu("srl_31",   5, 1'b0, 32'h80000000, 32'd31, 32'd1, 1'b0);
        alu("sra_31",   6, 1'b0, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0);
        alu("slt_s",    3, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b1);
        alu("slt_u",    3, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
        alu("passb",    9, 1'b0, 32'h0, 32'h12345000, 32'h12345000, 1'b1);
        alu("undef20", 20, 1'b0, 32'h55, 32'h3, 32'h0, 1'b0);
`ifdef ALU_MUL_EN
        alu("mul",     11, 1'b0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0);
        alu("mulh_s",  12, 1'b1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b1);
        alu("mulh_u",  12, 1'b0, 32'hFFFFFFFF, 32'd2, 32'h00000001, 1'b0);
`else
        alu("undef11", 11, 1'b0, 32'hFFFFFFFF, 32'd2, 32'h0, 1'b0);
        alu("undef12", 12, 1'b1, 32'hFFFFFFFF, 32'd2, 32'h0, 1'b1);
`endif

        // Randomized ALU against the model
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 31));
            s  = 1'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            e  = ref_alu(5'(op), s, a, b);
            alu($sformatf("rand_op%0d", op), op, s, a, b, e, ref_lt(s, a, b));
        end

        // Branch sweep
        for (int bc = 0; bc < 8; bc++)
            for (int zn = 0; zn < 4; zn++) begin
                branch = 3'(bc); br_zero = zn[0]; br_neg = zn[1];
                #1 chk($sformatf("pcsrc_b%0d_z%0d_n%0d", bc, zn[0], zn[1]),
                       {31'd0, pcsrc}, {31'd0, ref_pcsrc(bc, zn[0], zn[1])});
            end
        branch = 3'd1; br_zero = 1'b1; br_neg = 1'b0;
        #1 chk("beq_taken", {31'd0, pcsrc}, 32'd1);
        branch = 3'd4; br_zero = 1'b0; br_neg = 1'b1;
        #1 chk("bge_not_taken", {31'd0, pcsrc}, 32'd0);
        branch = 3'd5; br_zero = 1'b0; br_neg = 1'b0;
        #1 chk("jump", {31'd0, pcsrc}, 32'd1);
        branch = 3'd7; br_zero = 1'b1; br_neg = 1'b1;
        #1 chk("code7", {31'd0, pcsrc}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
